wb_bus_decoder: RTL and testbench
=================================

Name: wb_bus_decoder

Overview:
Single-master, three-slave Wishbone address decoder and response router between the cpu master port and the ROM, RAM and IO slaves. It registers each request and steers it to one slave by address window. It returns that slave's ack, err and read data to the master. It also generates err for unmapped addresses and for slaves that never respond (bus timeout).

Parameters:
S0_BASE, 64'h0000_8000_0000_0000, ROM window base (reset PC target)
S0_MASK, 64'hFFFF_FFFF_FFFF_0000, ROM window mask (64 KiB)
S1_BASE, 64'h0000_0000_0000_0000, RAM window base
S1_MASK, 64'hFFFF_FFFF_FFF0_0000, RAM window mask (1 MiB)
S2_BASE, 64'h0000_C000_0000_0000, IO window base
S2_MASK, 64'hFFFF_FFFF_FFFF_F000, IO window mask (4 KiB)
TIMEOUT, 16, cycles in BUSY without slave ack/err before err; 0 disables timeout

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_n_i  in  1  reset, asynchronous, active-low
m_adr_i  in  64  master address
m_dat_i  in  64  master write data
m_we_i  in  1  master write enable
m_sel_i  in  8  master byte selects
m_stb_i  in  1  master strobe
m_cyc_i  in  1  master cycle
m_dat_o  out  64  read data returned to master
m_ack_o  out  1  ack to master, single-cycle pulse
m_err_o  out  1  err to master, single-cycle pulse
s_adr_o  out  64  shared slave address (registered)
s_dat_o  out  64  shared slave write data (registered)
s_we_o  out  1  shared slave write enable
s_sel_o  out  8  shared slave byte selects
s_cyc_o  out  3  per-slave cycle, bit n = slave n
s_stb_o  out  3  per-slave strobe
s_dat_i  in  192  slave read data, slave n at [64n+63:64n]
s_ack_i  in  3  per-slave ack
s_err_i  in  3  per-slave err
err_cause_o  out  2  0 none, 1 decode miss, 2 slave err, 3 timeout; held until next accepted request

Behaviour:
- Reset (rst_n_i low, asynchronous): state IDLE; m_ack_o, m_err_o, s_cyc_o, s_stb_o, s_we_o = 0; m_dat_o, s_adr_o, s_dat_o = 0; s_sel_o = 0; err_cause_o = 0; timeout counter = 0. Reset asserted mid-transaction drops all slave strobes immediately and generates no ack or err.
- Decode: slave n matches when (m_adr_i & Sn_MASK) == Sn_BASE. Priority S0 > S1 > S2 on overlap.
- IDLE: on rising edge with m_cyc_i & m_stb_i:
  - Latch adr, dat, we and sel into the s_* outputs.
  - Clear err_cause_o and the counter.
  - On a match: latch index n and go to BUSY.
  - On no match: m_err_o = 1 next cycle, err_cause_o = 1, go to RELEASE. No slave strobe is ever asserted.
- BUSY: s_cyc_o[n] = s_stb_o[n] = 1; other bits 0. Counter increments each cycle. Only slave n's ack and err are observed; the others are ignored.
  - s_ack_i[n]: m_dat_o <= s_dat_i[n] (reads only; held on writes), m_ack_o pulses 1 cycle, strobes drop, go to RELEASE.
  - s_err_i[n] (ack wins if both): m_err_o pulses, err_cause_o = 2, strobes drop, go to RELEASE.
  - TIMEOUT != 0 and counter reaches TIMEOUT with neither ack nor err: m_err_o pulses, err_cause_o = 3, strobes drop, go to RELEASE.
  - m_cyc_i low (master abort): strobes drop, go to IDLE, no ack or err.
- Latency: request sampled at edge N. Slave strobe high from N+1. Slave ack sampled at edge M gives m_ack_o high in cycle M+1, and strobe is low from M+1. Minimum master turnaround is 3 cycles.
- RELEASE: wait until m_stb_i == 0, then go to IDLE. A new request is accepted only after m_stb_i has been low for at least 1 cycle; a master holding stb after ack never triggers a duplicate transfer.
- m_ack_o and m_err_o are never high together and are never high for more than 1 cycle.
- m_dat_o holds its last value between transfers.

Test Plan:
- ROM read at m_adr_i=0x0000_8000_0000_0000, slave 0 asserts ack with dat 0x1234_5678_9ABC_DEF0 two cycles after its strobe rises → s_stb_o=3'b001 for exactly 3 cycles; m_ack_o one cycle; m_dat_o=0x1234_5678_9ABC_DEF0; err_cause_o=0.
- RAM write to adr 0x10, dat 0xDEAD_BEEF, sel 8'h0F, immediate ack → s_stb_o=3'b010, s_we_o=1, s_sel_o=8'h0F, s_dat_o=0xDEAD_BEEF; m_ack_o pulses; m_dat_o unchanged.
- Unmapped adr 0x0000_4000_0000_0000 → s_stb_o stays 0 throughout; m_err_o one cycle after request; err_cause_o=1.
- IO read at 0x0000_C000_0000_0008, slave 2 silent, TIMEOUT=16 → s_stb_o[2] high for 16 cycles; m_err_o pulses once; err_cause_o=3. Repeat with s_err_i[2] at cycle 3 → err_cause_o=2.
- Master keeps stb high 5 cycles after ack, then drops it for 1 cycle, then re-requests → exactly two slave transfers.
- Master abort: drop m_cyc_i in BUSY → strobes drop next edge, no ack/err. Separately, assert rst_n_i low in BUSY → all outputs 0 asynchronously; the next request after release decodes normally.

Source files
------------

// File: rtl/wb_bus_decoder.sv
// Single-master Wishbone decoder: registers each request, steers it to the ROM, RAM or IO
// slave by address window, and routes ack/err/read data back, adding decode-miss and timeout errors.
module wb_bus_decoder #(
  parameter logic [63:0] S0_BASE = 64'h0000_8000_0000_0000,
  parameter logic [63:0] S0_MASK = 64'hFFFF_FFFF_FFFF_0000,
  parameter logic [63:0] S1_BASE = 64'h0000_0000_0000_0000,
  parameter logic [63:0] S1_MASK = 64'hFFFF_FFFF_FFF0_0000,
  parameter logic [63:0] S2_BASE = 64'h0000_C000_0000_0000,
  parameter logic [63:0] S2_MASK = 64'hFFFF_FFFF_FFFF_F000,
  parameter int          TIMEOUT = 16
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic [63:0]   m_adr_i,
  input  logic [63:0]   m_dat_i,
  input  logic          m_we_i,
  input  logic [7:0]    m_sel_i,
  input  logic          m_stb_i,
  input  logic          m_cyc_i,
  output logic [63:0]   m_dat_o,
  output logic          m_ack_o,
  output logic          m_err_o,
  output logic [63:0]   s_adr_o,
  output logic [63:0]   s_dat_o,
  output logic          s_we_o,
  output logic [7:0]    s_sel_o,
  output logic [2:0]    s_cyc_o,
  output logic [2:0]    s_stb_o,
  input  logic [191:0]  s_dat_i,
  input  logic [2:0]    s_ack_i,
  input  logic [2:0]    s_err_i,
  output logic [1:0]    err_cause_o
);

  typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      mDat_q, mDat_d;
  logic             mAck_q, mAck_d;
  logic             mErr_q, mErr_d;
  logic [63:0]      sAdr_q, sAdr_d;
  logic [63:0]      sDat_q, sDat_d;
  logic             sWe_q, sWe_d;
  logic [7:0]       sSel_q, sSel_d;
  logic [1:0]       cause_q, cause_d;

  logic [2:0]       hit;
  logic             slvAck, slvErr, timeoutHit;
  logic [63:0]      slvRdata;
  logic [2:0]       stbVec;

  assign hit[0] = (m_adr_i & S0_MASK) == S0_BASE;
  assign hit[1] = (m_adr_i & S1_MASK) == S1_BASE;
  assign hit[2] = (m_adr_i & S2_MASK) == S2_BASE;

  assign timeoutHit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

  // Only the slave that owns the current transfer is listened to
  always_comb begin
    slvAck   = 1'b0;
    slvErr   = 1'b0;
    slvRdata = '0;
    case (idx_q)
      2'd0: begin slvAck = s_ack_i[0]; slvErr = s_err_i[0]; slvRdata = s_dat_i[63:0];    end
      2'd1: begin slvAck = s_ack_i[1]; slvErr = s_err_i[1]; slvRdata = s_dat_i[127:64];  end
      2'd2: begin slvAck = s_ack_i[2]; slvErr = s_err_i[2]; slvRdata = s_dat_i[191:128]; end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    mDat_d  = mDat_q;
    mAck_d  = 1'b0;
    mErr_d  = 1'b0;
    sAdr_d  = sAdr_q;
    sDat_d  = sDat_q;
    sWe_d   = sWe_q;
    sSel_d  = sSel_q;
    cause_d = cause_q;
    case (state_q)
      IDLE: begin
        if (m_cyc_i && m_stb_i) begin
          sAdr_d  = m_adr_i;
          sDat_d  = m_dat_i;
          sWe_d   = m_we_i;
          sSel_d  = m_sel_i;
          cause_d = 2'd0;
          cnt_d   = '0;
          if (hit[0]) begin
            idx_d   = 2'd0;
            state_d = BUSY;
          end else if (hit[1]) begin
            idx_d   = 2'd1;
            state_d = BUSY;
          end else if (hit[2]) begin
            idx_d   = 2'd2;
            state_d = BUSY;
          end else begin
            mErr_d  = 1'b1;
            cause_d = 2'd1;
            state_d = RELEASE;
          end
        end
      end
      // An abort by the master beats any response arriving in the same cycle
      BUSY: begin
        if (!m_cyc_i) begin
          state_d = IDLE;
        end else if (slvAck) begin
          mAck_d  = 1'b1;
          if (!sWe_q) mDat_d = slvRdata;
          state_d = RELEASE;
        end else if (slvErr) begin
          mErr_d  = 1'b1;
          cause_d = 2'd2;
          state_d = RELEASE;
        end else if (timeoutHit) begin
          mErr_d  = 1'b1;
          cause_d = 2'd3;
          state_d = RELEASE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RELEASE: begin
        if (!m_stb_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      cnt_q   <= '0;
      mDat_q  <= '0;
      mAck_q  <= 1'b0;
      mErr_q  <= 1'b0;
      sAdr_q  <= '0;
      sDat_q  <= '0;
      sWe_q   <= 1'b0;
      sSel_q  <= '0;
      cause_q <= 2'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      mDat_q  <= mDat_d;
      mAck_q  <= mAck_d;
      mErr_q  <= mErr_d;
      sAdr_q  <= sAdr_d;
      sDat_q  <= sDat_d;
      sWe_q   <= sWe_d;
      sSel_q  <= sSel_d;
      cause_q <= cause_d;
    end
  end

  // Strobes are decoded straight from the state so reset kills them without waiting for a clock
  assign stbVec = (state_q == BUSY) ? (3'b001 << idx_q) : 3'b000;

  assign s_cyc_o     = stbVec;
  assign s_stb_o     = stbVec;
  assign m_dat_o     = mDat_q;
  assign m_ack_o     = mAck_q;
  assign m_err_o     = mErr_q;
  assign s_adr_o     = sAdr_q;
  assign s_dat_o     = sDat_q;
  assign s_we_o      = sWe_q;
  assign s_sel_o     = sSel_q;
  assign err_cause_o = cause_q;

endmodule

// File: tb/tb_wb_bus_decoder.sv
// Scoreboard bench for wb_bus_decoder: the driver predicts each response from the address
// windows and the slave behaviour it programs; a monitor pops and compares on every ack/err.
module tb_wb_bus_decoder;

  localparam logic [63:0] S0_BASE = 64'h0000_8000_0000_0000;
  localparam logic [63:0] S0_MASK = 64'hFFFF_FFFF_FFFF_0000;
  localparam logic [63:0] S1_BASE = 64'h0000_0000_0000_0000;
  localparam logic [63:0] S1_MASK = 64'hFFFF_FFFF_FFF0_0000;
  localparam logic [63:0] S2_BASE = 64'h0000_C000_0000_0000;
  localparam logic [63:0] S2_MASK = 64'hFFFF_FFFF_FFFF_F000;
  localparam int          TIMEOUT = 16;

  logic          clk_i = 1'b0;
  logic          rst_n_i = 1'b1;
  logic [63:0]   m_adr_i = '0;
  logic [63:0]   m_dat_i = '0;
  logic          m_we_i = 1'b0;
  logic [7:0]    m_sel_i = '0;
  logic          m_stb_i = 1'b0;
  logic          m_cyc_i = 1'b0;
  logic [63:0]   m_dat_o;
  logic          m_ack_o;
  logic          m_err_o;
  logic [63:0]   s_adr_o;
  logic [63:0]   s_dat_o;
  logic          s_we_o;
  logic [7:0]    s_sel_o;
  logic [2:0]    s_cyc_o;
  logic [2:0]    s_stb_o;
  logic [191:0]  s_dat_i = '0;
  logic [2:0]    s_ack_i = '0;
  logic [2:0]    s_err_i = '0;
  logic [1:0]    err_cause_o;

  always #5 clk_i = ~clk_i;

  wb_bus_decoder #(
    .S0_BASE(S0_BASE), .S0_MASK(S0_MASK),
    .S1_BASE(S1_BASE), .S1_MASK(S1_MASK),
    .S2_BASE(S2_BASE), .S2_MASK(S2_MASK),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_we_i(m_we_i), .m_sel_i(m_sel_i),
    .m_stb_i(m_stb_i), .m_cyc_i(m_cyc_i),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
    .err_cause_o(err_cause_o)
  );

  typedef struct {
    bit          isErr;
    logic [63:0] dat;
    logic [1:0]  cause;
    int          stbCycles;
  } exp_t;

  exp_t        expQ[$];
  int          checks = 0;
  int          fails = 0;
  int          transfers = 0;
  int          expTransfers = 0;
  int          stbCycles = 0;
  logic [63:0] lastRead = '0;

  logic [2:0]  curStb = '0;
  logic [63:0] curAdr = '0;
  logic [63:0] curDat = '0;
  logic        curWe = 1'b0;
  logic [7:0]  curSel = '0;

  // Slave behaviour: 0 ack, 1 err, 2 silent; response comes slvLat cycles after strobe rises
  int          slvMode = 0;
  int          slvLat = 0;
  int          slvCnt = 0;
  logic [63:0] slvData = '0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: actual=%h expected=%h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic bit inWindow(input logic [63:0] adr, input logic [63:0] base, input logic [63:0] mask);
    logic [63:0] size;
    size = ~mask + 64'd1;
    return (adr >= base) && ((adr - base) < size);
  endfunction

  function automatic int decodeRef(input logic [63:0] adr);
    if (inWindow(adr, S0_BASE, S0_MASK)) return 0;
    if (inWindow(adr, S1_BASE, S1_MASK)) return 1;
    if (inWindow(adr, S2_BASE, S2_MASK)) return 2;
    return -1;
  endfunction

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_m_ack"}, 64'(m_ack_o), 64'd0);
    checkOutput({tag, "_m_err"}, 64'(m_err_o), 64'd0);
    checkOutput({tag, "_m_dat"}, m_dat_o, 64'd0);
    checkOutput({tag, "_s_adr"}, s_adr_o, 64'd0);
    checkOutput({tag, "_s_dat"}, s_dat_o, 64'd0);
    checkOutput({tag, "_s_we"}, 64'(s_we_o), 64'd0);
    checkOutput({tag, "_s_sel"}, 64'(s_sel_o), 64'd0);
    checkOutput({tag, "_s_cyc"}, 64'(s_cyc_o), 64'd0);
    checkOutput({tag, "_s_stb"}, 64'(s_stb_o), 64'd0);
    checkOutput({tag, "_cause"}, 64'(err_cause_o), 64'd0);
  endtask

  task automatic setupRequest(input logic [63:0] adr, input logic we, input logic [63:0] dat,
                              input logic [7:0] sel, input int idx);
    curStb = (idx < 0) ? 3'b000 : 3'(1 << idx);
    curAdr = adr;
    curDat = dat;
    curWe  = we;
    curSel = sel;
    if (idx >= 0) expTransfers++;
    stbCycles = 0;
    m_adr_i = adr;
    m_dat_i = dat;
    m_we_i  = we;
    m_sel_i = sel;
    m_cyc_i = 1'b1;
    m_stb_i = 1'b1;
  endtask

  task automatic applyStimulus(input logic [63:0] adr, input logic we, input logic [63:0] dat,
                               input logic [7:0] sel, input int mode, input int lat,
                               input logic [63:0] rdata, input int hold);
    exp_t e;
    int   idx;
    logic got;
    idx = decodeRef(adr);
    slvMode = mode;
    slvLat  = lat;
    slvData = rdata;
    if (idx < 0) begin
      e.isErr = 1'b1; e.cause = 2'd1; e.stbCycles = 0;
    end else if (mode == 0) begin
      e.isErr = 1'b0; e.cause = 2'd0; e.stbCycles = lat + 1;
      if (!we) lastRead = rdata;
    end else if (mode == 1) begin
      e.isErr = 1'b1; e.cause = 2'd2; e.stbCycles = lat + 1;
    end else begin
      e.isErr = 1'b1; e.cause = 2'd3; e.stbCycles = TIMEOUT;
    end
    e.dat = lastRead;
    expQ.push_back(e);
    setupRequest(adr, we, dat, sel, idx);
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      tick();
      got = m_ack_o | m_err_o;
    end
    if (!got) checkOutput("resp_wait", 64'(got), 64'd1);
    repeat (hold) tick();
    m_cyc_i = 1'b0;
    m_stb_i = 1'b0;
    tick();
  endtask

  task automatic applyAbort(input logic [63:0] adr, input int k);
    slvMode = 2;
    setupRequest(adr, 1'b0, 64'h0, 8'hFF, decodeRef(adr));
    repeat (k) tick();
    m_cyc_i = 1'b0;
    m_stb_i = 1'b0;
    tick();
    checkOutput("abort_stb", 64'(s_stb_o), 64'd0);
    checkOutput("abort_cyc", 64'(s_cyc_o), 64'd0);
    repeat (3) tick();
  endtask

  // Slave models plus ack/err noise on the slaves that do not own the transfer
  initial begin
    forever begin
      tick();
      s_ack_i = 3'($urandom) & ~s_stb_o;
      s_err_i = 3'($urandom) & ~s_stb_o;
      s_dat_i = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      if (s_stb_o != 3'b000) begin
        if (slvMode != 2 && slvCnt == slvLat) begin
          for (int n = 0; n < 3; n++) if (s_stb_o[n]) s_dat_i[64*n +: 64] = slvData;
          if (slvMode == 0) begin
            s_ack_i = s_ack_i | s_stb_o;
            if ($urandom_range(0, 1) == 1) s_err_i = s_err_i | s_stb_o;
          end else begin
            s_err_i = s_err_i | s_stb_o;
          end
        end
        slvCnt++;
      end else begin
        slvCnt = 0;
      end
    end
  end

  initial begin
    exp_t e;
    logic prevStb = 1'b0;
    logic prevResp = 1'b0;
    logic resp;
    forever begin
      @(negedge clk_i);
      if (s_stb_o != 3'b000 && !prevStb) begin
        transfers++;
        checkOutput("stb_select", 64'(s_stb_o), 64'(curStb));
        checkOutput("cyc_select", 64'(s_cyc_o), 64'(curStb));
        checkOutput("s_adr", s_adr_o, curAdr);
        checkOutput("s_dat", s_dat_o, curDat);
        checkOutput("s_we", 64'(s_we_o), 64'(curWe));
        checkOutput("s_sel", 64'(s_sel_o), 64'(curSel));
      end
      if (s_stb_o != 3'b000) stbCycles++;
      resp = m_ack_o | m_err_o;
      if (resp) begin
        checkOutput("resp_pulse", 64'(prevResp), 64'd0);
        checkOutput("ack_err_excl", 64'(m_ack_o & m_err_o), 64'd0);
        if (expQ.size() == 0) begin
          checkOutput("unexpected_resp", 64'(resp), 64'd0);
        end else begin
          e = expQ.pop_front();
          checkOutput("resp_ack", 64'(m_ack_o), 64'(!e.isErr));
          checkOutput("resp_err", 64'(m_err_o), 64'(e.isErr));
          checkOutput("m_dat", m_dat_o, e.dat);
          checkOutput("err_cause", 64'(err_cause_o), 64'(e.cause));
          checkOutput("stb_cycles", 64'(stbCycles), 64'(e.stbCycles));
          checkOutput("stb_dropped", 64'(s_stb_o), 64'd0);
        end
      end
      prevStb  = (s_stb_o != 3'b000);
      prevResp = resp;
    end
  end

  initial begin
    int cls;
    int mode;
    logic [63:0] a;
    #1 rst_n_i = 1'b0;
    #2 checkAllZero("reset");
    repeat (2) @(posedge clk_i);
    #3 rst_n_i = 1'b1;
    tick();

    applyStimulus(64'h0000_8000_0000_0000, 1'b0, 64'h0, 8'hFF, 0, 2, 64'h1234_5678_9ABC_DEF0, 0);
    applyStimulus(64'h0000_0000_0000_0010, 1'b1, 64'hDEAD_BEEF, 8'h0F, 0, 0, 64'h5555_AAAA_5555_AAAA, 0);
    applyStimulus(64'h0000_4000_0000_0000, 1'b0, 64'h0, 8'hFF, 0, 0, 64'h0, 0);
    applyStimulus(64'h0000_C000_0000_0008, 1'b0, 64'h0, 8'hFF, 2, 0, 64'h0, 0);
    applyStimulus(64'h0000_C000_0000_0008, 1'b0, 64'h0, 8'hFF, 1, 2, 64'h0, 0);
    applyStimulus(64'h0000_0000_0000_0100, 1'b0, 64'h0, 8'hFF, 0, 1, 64'hCAFE_F00D_0000_0001, 5);
    applyStimulus(64'h0000_0000_0000_0108, 1'b0, 64'h0, 8'hFF, 0, 0, 64'hCAFE_F00D_0000_0002, 0);
    applyAbort(64'h0000_C000_0000_0010, 3);

    // Reset in the middle of a silent IO transfer
    slvMode = 2;
    setupRequest(64'h0000_C000_0000_0020, 1'b1, 64'h77, 8'h3C, 2);
    repeat (4) tick();
    #2 rst_n_i = 1'b0;
    #1 checkAllZero("rst_busy");
    m_cyc_i  = 1'b0;
    m_stb_i  = 1'b0;
    lastRead = '0;
    repeat (2) tick();
    #2 rst_n_i = 1'b1;
    tick();
    applyStimulus(64'h0000_8000_0000_0040, 1'b0, 64'h0, 8'hFF, 0, 1, 64'h0BAD_C0DE_1111_2222, 0);

    for (int t = 0; t < 40; t++) begin
      cls = $urandom_range(0, 3);
      a = {$urandom, $urandom};
      case (cls)
        0: a = S0_BASE | (a & ~S0_MASK);
        1: a = S1_BASE | (a & ~S1_MASK);
        2: a = S2_BASE | (a & ~S2_MASK);
        default: ;
      endcase
      mode = $urandom_range(0, 9);
      mode = (mode < 6) ? 0 : ((mode < 9) ? 1 : 2);
      applyStimulus(a, 1'($urandom_range(0, 1)), {$urandom, $urandom}, 8'($urandom),
                    mode, $urandom_range(0, 4), {$urandom, $urandom}, $urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) tick();
    end

    repeat (5) tick();
    checkOutput("pending_resp", 64'(expQ.size()), 64'd0);
    checkOutput("transfer_count", 64'(transfers), 64'(expTransfers));
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
